// File: rtl/aes_dec_pkg.sv
// Shared constants and types for the AES-128 decryption key schedule.
package aes_dec_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON [0:NR-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        SERVE
    } state_e;

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key expansion round: previous round key plus rcon -> next round key.
// Purely combinational so an encryption-side schedule can reuse it.
module key_expand_step (
    input  logic [127:0] prev_key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] next_key_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte of the table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, t_w;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key_i[127:96];
    assign w1 = prev_key_i[95:64];
    assign w2 = prev_key_i[63:32];
    assign w3 = prev_key_i[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};
    assign t_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                    sbox(rot_w[15:8]),  sbox(rot_w[7:0])} ^ {rcon_i, 24'h0};

    assign n0 = w0 ^ t_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/decrypt_key_schedule.sv
// Iterative AES-128 key schedule: expands one round key per cycle into a
// register file, then streams round keys 10 down to 0, replaying per block.
module decrypt_key_schedule
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    input  logic         rekey,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         busy
);

    localparam logic [3:0] NR_Q = 4'(NR);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] rk_mem_q [0:NR];

    logic         mem_we;
    logic [3:0]   mem_waddr;
    logic [127:0] mem_wdata;
    logic [3:0]   step_sel;
    logic [127:0] step_key;

    assign step_sel = cnt_q - 4'd1;

    key_expand_step u_step (
        .prev_key_i (rk_mem_q[step_sel]),
        .rcon_i     (RCON[step_sel]),
        .next_key_o (step_key)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = step_key;

        if (rekey) begin
            // A rekey wins over key capture, expansion and the rk handshake.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = 4'd0;
                        mem_wdata = key;
                        cnt_d     = 4'd1;
                        state_d   = EXPAND;
                    end
                end
                EXPAND: begin
                    mem_we = 1'b1;
                    if (cnt_q == NR_Q) begin
                        cnt_d   = 4'd0;
                        idx_d   = NR_Q;
                        state_d = SERVE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                SERVE: begin
                    if (rk_ready) begin
                        idx_d = (idx_q == 4'd0) ? NR_Q : idx_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= NR_Q;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the key file is reset so rk reads 0 after reset and a half-built schedule never leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                rk_mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            rk_mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q == EXPAND);
    assign rk_valid  = (state_q == SERVE);
    assign rk        = rk_mem_q[idx_q];
    assign rk_idx    = idx_q;
    assign rk_last   = rk_valid && (idx_q == 4'd0);

endmodule

// File: tb/tb_decrypt_key_schedule.sv
// Scoreboard bench for decrypt_key_schedule using FIPS-197 key schedule vectors.
module tb_decrypt_key_schedule;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rekey;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    decrypt_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rekey     (rekey),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         last;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int idx, input logic [127:0] value);
        exp_t e;
        e.idx  = 4'(idx);
        e.rk   = value;
        e.last = (idx == 0);
        exp_q.push_back(e);
    endfunction

    function automatic void push_fips_block();
        for (int i = 10; i >= 0; i--) push_exp(i, FIPS_RK[i]);
    endfunction

    // Monitor: pops the scoreboard on every accepted round key and checks stall stability.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                check("stall_valid", rk_valid, 1);
                check("stall_rk", rk, prev_rk);
                check("stall_idx", rk_idx, prev_idx);
            end
            if (rk_valid && rk_ready && !rekey && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_handshake: idx=%0d rk=%h with empty queue", rk_idx, rk);
                end else begin
                    e = exp_q.pop_front();
                    check("rk_idx", rk_idx, e.idx);
                    check("rk_value", rk, e.rk);
                    check("rk_last", rk_last, e.last);
                end
            end
            prev_stall = rk_valid && !rk_ready && !rekey && !rst;
            prev_rk    = rk;
            prev_idx   = rk_idx;
        end
    end

    task automatic send_key(input logic [127:0] k);
        int n = 0;
        while (!key_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("key_ready_wait", key_ready, 1);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Loads a key and measures the cycles until rk_valid; optionally pulses a bogus key mid-expansion.
    task automatic load_key(input logic [127:0] k, input bit junk);
        int n = 0;
        send_key(k);
        while (!rk_valid && n < 40) begin
            if (junk && n >= 2 && n <= 4) begin
                key_valid = 1'b1;
                key       = ~k;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (junk && n == 3) begin
                check("expand_busy", busy, 1);
                check("expand_key_ready", key_ready, 0);
            end
        end
        key_valid = 1'b0;
        check("latency", n, 10);
    endtask

    task automatic drain(input bit random_ready, output int cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            if (random_ready) rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        cycles = n;
    endtask

    task automatic pulse_rekey();
        rekey = 1'b1;
        @(posedge clk); #1;
        rekey = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        rekey     = 1'b0;
        rk_ready  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rk_valid", rk_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_key_ready", key_ready, 1);
        check("idle_rk_valid", rk_valid, 0);
        check("idle_rk", rk, 0);
        check("idle_rk_idx", rk_idx, 10);
        check("idle_rk_last", rk_last, 0);
        check("idle_busy", busy, 0);

        // FIPS key, two back-to-back blocks with rk_ready held high.
        @(posedge clk); #1;
        rk_ready = 1'b1;
        push_fips_block();
        push_fips_block();
        load_key(FIPS_KEY, 1'b0);
        drain(1'b0, cyc);
        check("throughput_2_blocks", cyc, 22);
        rk_ready = 1'b0;

        // Random backpressure over three blocks.
        push_fips_block();
        push_fips_block();
        push_fips_block();
        drain(1'b1, cyc);
        rk_ready = 1'b0;

        // Key offered during SERVE is ignored.
        key       = ~FIPS_KEY;
        key_valid = 1'b1;
        @(negedge clk);
        check("serve_key_ready", key_ready, 0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        push_fips_block();
        rk_ready = 1'b1;
        drain(1'b0, cyc);
        rk_ready = 1'b0;

        // Reload with a bogus key pulsed during EXPAND.
        pulse_rekey();
        check("rekey_key_ready", key_ready, 1);
        push_fips_block();
        rk_ready = 1'b1;
        load_key(FIPS_KEY, 1'b1);
        drain(1'b0, cyc);
        rk_ready = 1'b0;

        // Rekey coinciding with the idx 5 handshake.
        for (int i = 10; i >= 6; i--) push_exp(i, FIPS_RK[i]);
        rk_ready = 1'b1;
        drain(1'b0, cyc);
        check("pre_rekey_idx", rk_idx, 5);
        pulse_rekey();
        rk_ready = 1'b0;
        check("post_rekey_valid", rk_valid, 0);
        check("post_rekey_key_ready", key_ready, 1);
        check("post_rekey_idx", rk_idx, 5);

        push_exp(10, K2_RK10);
        rk_ready = 1'b1;
        load_key(K2_KEY, 1'b0);
        drain(1'b0, cyc);
        rk_ready = 1'b0;

        // Asynchronous reset in the middle of expansion.
        pulse_rekey();
        send_key(FIPS_KEY);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_key_ready", key_ready, 1);
        check("async_rst_rk_valid", rk_valid, 0);
        check("async_rst_rk", rk, 0);
        check("async_rst_rk_idx", rk_idx, 10);
        check("async_rst_rk_last", rk_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        push_fips_block();
        rk_ready = 1'b1;
        load_key(FIPS_KEY, 1'b0);
        drain(1'b0, cyc);
        rk_ready = 1'b0;

        repeat (2) @(posedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
